mul_div_unit: RTL
=================

# mul_div_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the register file. It consumes the two read ports (readData1/readData2) as operands, computes one of the eight M-extension operations over a fixed multi-cycle schedule, and returns the result on a write-back port shaped for the register file's synchronous write side (writeRegister/writeData/regWrite). The datapath stalls on `busy` and issues at most one operation at a time.

## Interface
- No parameters; fixed XLEN = 32.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- start  input  1  operation request; accepted only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operandA  input  32  rs1 value (from readData1).
- operandB  input  32  rs2 value (from readData2).
- destRegister  input  5  rd index, captured with the operands.
- busy  output  1  high from acceptance until the DONE cycle inclusive.
- done  output  1  one-cycle completion pulse.
- result  output  32  write-back data; holds its value until the next completion.
- writeRegister  output  5  captured rd, valid while done=1.
- regWrite  output  1  done && (captured rd != 0).

## Operation
- States: IDLE, CALC, DONE.
- IDLE: when start=1, capture funct3, operands and rd, and clear the 6-bit iteration counter.
  - Special-case ops go to DONE immediately; all other ops go to CALC.
- Special cases (DONE directly):
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> operandA.
  - Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Sign handling:
  - Signed operands (A for MULH/MULHSU/DIV/REM; B for MULH/DIV/REM) are converted to magnitudes at capture. The unsigned core then runs on the magnitudes.
  - The sign is restored in DONE on a 64-bit product or on the quotient/remainder.
  - Product sign = XOR of the signed operands' signs.
  - Quotient sign = XOR of the operand signs; remainder sign = dividend sign.
- Multiply core: shift-add over a 64-bit accumulator, one multiplier bit per CALC cycle.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32] after sign fix.
- Divide core: restoring division, one quotient bit per CALC cycle.
  - 32-bit remainder register plus a 33-bit trial subtract.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- CALC runs exactly 32 iterations (counter 0..31), then goes to DONE.
- DONE: drive result and the done/regWrite pulse, then return to IDLE.
- start while busy is ignored: no capture, in-flight op unaffected.
- rd = x0: done still pulses, regWrite stays 0, result still updates.

## Timing
- Reset (any state, including mid-CALC) forces IDLE.
  - busy=0, done=0, regWrite=0, result=0, writeRegister=0, counter=0.
  - An aborted op never produces done.
- Normal op, start accepted at edge k:
  - busy=1 after edge k.
  - CALC iterations at edges k+1..k+32.
  - done/regWrite=1 for the single cycle after edge k+32.
  - busy=0 and state=IDLE after edge k+33.
  - Total latency 33 cycles.
- Special case, start accepted at edge k: done=1 for the cycle after edge k, IDLE after edge k+1. Latency 1 cycle.
- A new start is accepted no earlier than the edge at which the unit is back in IDLE (edge k+33 normal, k+1 special). Back-to-back issue has a 1-cycle gap minimum.
- Outputs are registered; no combinational path from inputs to outputs.
- result, writeRegister and done change together in the same cycle.
- Operand inputs may change freely after the accepting edge.

## Test plan
- Reset, then MUL 7 × 0xFFFFFFFD (-3), rd=5 -> done exactly 33 cycles after the start edge, result 0xFFFFFFEB, writeRegister 5, regWrite 1 for one cycle.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, done 1 cycle after start. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Reset asserted 10 cycles into a DIV -> all outputs 0, no done ever. A following MUL 3×4 -> 12 at the normal latency.
- start pulsed again mid-CALC with different operands -> ignored, original result returned. MUL 2×3 with rd=0 -> done=1, regWrite=0, result 6.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit with register-file write-back port
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [4:0]  destRegister,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  writeRegister,
    output logic        regWrite
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;

    logic [2:0]  op_q;
    logic [31:0] divisor_q;
    logic [63:0] acc_q, acc_step;
    logic [4:0]  rd_q;
    logic [5:0]  cnt_q;
    logic        neg_q;
    logic        done_q, regwrite_q;
    logic [31:0] result_q;
    logic [4:0]  wreg_q;

    logic        a_signed, b_signed, div_zero, div_ovf, special, neg_d;
    logic [31:0] mag_a, mag_b, special_res;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        mag_a = (a_signed && operandA[31]) ? (~operandA + 32'd1) : operandA;
        mag_b = (b_signed && operandB[31]) ? (~operandB + 32'd1) : operandB;
        // remainder takes the dividend's sign; everything else the XOR of signed operands
        neg_d = (funct3 == 3'b110) ? operandA[31]
                                   : ((a_signed & operandA[31]) ^ (b_signed & operandB[31]));
        div_zero = funct3[2] && (operandB == 32'd0);
        div_ovf  = funct3[2] && !funct3[0] && (operandA == 32'h8000_0000) && (operandB == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = funct3[1] ? operandA : 32'hFFFF_FFFF;
        else
            special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [32:0] mul_sum;
    logic [33:0] trial;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix, final_res;

    always_comb begin
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, divisor_q} : 33'd0);
        trial   = {1'b0, acc_q[63:31]} - {2'b00, divisor_q};
        if (!op_q[2])
            acc_step = {mul_sum, acc_q[31:1]};
        else if (!trial[33])
            acc_step = {trial[31:0], acc_q[30:0], 1'b1};
        else
            acc_step = {acc_q[62:0], 1'b0};
        prod_fix = neg_q ? (~acc_step + 64'd1) : acc_step;
        quot_fix = neg_q ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
        rem_fix  = neg_q ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
        case (op_q)
            3'b000:                 final_res = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[63:32];
            3'b100, 3'b101:         final_res = quot_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == 6'd31) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= 3'd0;
            divisor_q  <= 32'd0;
            acc_q      <= 64'd0;
            rd_q       <= 5'd0;
            cnt_q      <= 6'd0;
            neg_q      <= 1'b0;
            done_q     <= 1'b0;
            regwrite_q <= 1'b0;
            result_q   <= 32'd0;
            wreg_q     <= 5'd0;
        end else begin
            done_q     <= 1'b0;
            regwrite_q <= 1'b0;
            if (state_q == IDLE && start) begin
                op_q      <= funct3;
                divisor_q <= mag_b;
                acc_q     <= {32'd0, mag_a};
                rd_q      <= destRegister;
                neg_q     <= neg_d;
                cnt_q     <= 6'd0;
                if (special) begin
                    result_q   <= special_res;
                    wreg_q     <= destRegister;
                    done_q     <= 1'b1;
                    regwrite_q <= (destRegister != 5'd0);
                end
            end else if (state_q == CALC) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + 6'd1;
                // last iteration: sign-fix the freshly computed value straight into result
                if (cnt_q == 6'd31) begin
                    result_q   <= final_res;
                    wreg_q     <= rd_q;
                    done_q     <= 1'b1;
                    regwrite_q <= (rd_q != 5'd0);
                end
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign regWrite      = regwrite_q;
    assign result        = result_q;
    assign writeRegister = wreg_q;
endmodule
